mem_port_arbiter: RTL

Round-robin arbiter that shares the single main-memory generic-bus port between NREQ requesters, such as the coherence bus controller's L2 side and a non-cacheable/DMA path.
- Grants one owner at a time and muxes the owner's request onto the memory port.
- Supports a lock input so multi-word block transfers stay atomic.
- Provides a memory-stall watchdog and per-requester grant counters for the stress benches.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_picker.sv | 26 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory-port arbiter and its round-robin picker.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NREQ.
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any_req
);

  localparam int OW = $clog2(NREQ);

  always_comb begin
    winner  = last;
    any_req = |req;
    // Walk the ring backwards so the nearest requester after 'last' is written last and wins.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        winner = OW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single main-memory port, with lock, stall watchdog and grant counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*BE_W-1:0]     req_byte_en,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ*DATA_W-1:0]   req_rdata,
  output logic [NREQ-1:0]          req_busy,
  output logic [ADDR_W-1:0]        memory_addr,
  output logic [DATA_W-1:0]        memory_wdata,
  output logic [BE_W-1:0]          memory_byte_en,
  output logic                     memory_ren,
  output logic                     memory_wen,
  input  logic [DATA_W-1:0]        memory_rdata,
  input  logic                     memory_busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     grant_valid,
  output logic                     timeout_err,
  output logic                     proto_err,
  output logic [NREQ*CNT_W-1:0]    grant_count
);

  localparam int OW   = $clog2(NREQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  // Handshake: req(i) = ren|wen is valid, ~req_busy[i] is ready; an access completes on a
  // cycle where both hold for the owner. Valid must stay up until ready or the owner aborts.

  arb_state_t        state, state_nxt;
  logic [OW-1:0]     owner_q;
  logic [NREQ-1:0]   req_vec;
  logic              req_o, ren_o, wen_o, lock_o;
  logic [OW-1:0]     winner;
  logic              any_req;
  logic [CNT_W-1:0]  cnt_q [NREQ];
  logic [WD_W-1:0]   wd_q;

  assign req_vec     = req_ren | req_wen;
  assign req_o       = req_vec[owner_q];
  assign ren_o       = req_ren[owner_q];
  assign wen_o       = req_wen[owner_q];
  assign lock_o      = req_lock[owner_q];
  assign owner       = owner_q;
  assign grant_valid = (state == ACTIVE);

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req_vec),
    .last    (owner_q),
    .winner  (winner),
    .any_req (any_req)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_count[CNT_W*g +: CNT_W] = cnt_q[g];
  end

  always_comb begin
    state_nxt      = state;
    memory_addr    = '0;
    memory_wdata   = '0;
    memory_byte_en = '0;
    memory_ren     = 1'b0;
    memory_wen     = 1'b0;
    req_busy       = '1;
    req_rdata      = '0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        memory_addr    = req_addr[ADDR_W*owner_q +: ADDR_W];
        memory_wdata   = req_wdata[DATA_W*owner_q +: DATA_W];
        memory_byte_en = req_byte_en[BE_W*owner_q +: BE_W];
        memory_wen     = wen_o;
        memory_ren     = ren_o & ~wen_o;
        for (int i = 0; i < NREQ; i++) begin
          if (owner_q == OW'(i)) begin
            req_busy[i]                   = memory_busy;
            req_rdata[DATA_W*i +: DATA_W] = memory_rdata;
          end
        end
        if (!req_o) begin
          state_nxt = IDLE;
        end else if (!memory_busy) begin
          state_nxt = lock_o ? ACTIVE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      owner_q     <= OW'(NREQ - 1);
      wd_q        <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner_q <= winner;
        if (cnt_q[winner] != '1) cnt_q[winner] <= cnt_q[winner] + CNT_W'(1);
      end
      if (state == ACTIVE && req_o && memory_busy) begin
        if (wd_q != WD_W'(TIMEOUT)) wd_q <= wd_q + WD_W'(1);
        if (wd_q >= WD_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
      end else begin
        wd_q <= '0;
      end
      if (state == ACTIVE && ren_o && wen_o) proto_err <= 1'b1;
    end
  end

endmodule
